// File: rtl/uctl_ahbmstrarb.sv
// Two-way round-robin arbiter sharing one AHB master core between the DMA Rx and Tx engines.
// Request to ahbc is registered (1 clk); handshakes back to engines are combinational; watchdog aborts unacked grants.
module uctl_ahbmstrarb #(
  parameter int ADDR_SIZE = 32,
  parameter int TMO_WD    = 8,
  parameter int TMO_CNT   = 200
) (
  input  logic                 uctl_sysClk,
  input  logic                 uctl_sysRst_n,
  input  logic                 rx2arb_trEn,
  input  logic [4:0]           rx2arb_beats,
  input  logic [2:0]           rx2arb_hSize,
  input  logic [ADDR_SIZE-1:0] rx2arb_sWrAddr,
  input  logic                 rx2arb_sRdWr,
  input  logic                 tx2arb_trEn,
  input  logic [4:0]           tx2arb_beats,
  input  logic [2:0]           tx2arb_hSize,
  input  logic [ADDR_SIZE-1:0] tx2arb_sWrAddr,
  input  logic                 tx2arb_sRdWr,
  output logic                 arb2rx_ack,
  output logic                 arb2rx_addrDn,
  output logic                 arb2rx_dataDn,
  output logic                 arb2tx_ack,
  output logic                 arb2tx_addrDn,
  output logic                 arb2tx_dataDn,
  output logic [ADDR_SIZE-1:0] arb2eng_sWrAddr,
  output logic                 arb2ahbc_trEn,
  output logic [4:0]           arb2ahbc_beats,
  output logic [2:0]           arb2ahbc_hSize,
  output logic [ADDR_SIZE-1:0] arb2ahbc_sWrAddr,
  output logic                 arb2ahbc_sRdWr,
  input  logic                 ahbc2arb_ack,
  input  logic                 ahbc2arb_addrDn,
  input  logic                 ahbc2arb_dataDn,
  input  logic [ADDR_SIZE-1:0] ahbc2arb_sWrAddr,
  output logic [1:0]           arb_aOwn,
  output logic                 arb_tmoErr
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ADDR} state_t;

  localparam logic [1:0]        OWN_NONE = 2'b00;
  localparam logic [1:0]        OWN_RX   = 2'b01;
  localparam logic [1:0]        OWN_TX   = 2'b10;
  localparam logic [TMO_WD-1:0] TMO_LAST = TMO_WD'(TMO_CNT - 1);

  state_t                 state_q;
  logic                   last_tx_q;
  logic [1:0]             a_own_q;
  logic [1:0]             d_own_q;
  logic [TMO_WD-1:0]      cnt_q;
  logic                   tren_q;
  logic [4:0]             beats_q;
  logic [2:0]             hsize_q;
  logic [ADDR_SIZE-1:0]   addr_q;
  logic                   rdwr_q;
  logic                   tmo_q;

  logic       any_req;
  logic       rx_win;
  logic [1:0] ack_own;
  logic [1:0] data_own;
  logic [1:0] d_own_d;

  assign any_req  = rx2arb_trEn | tx2arb_trEn;
  // On a tie Rx wins only if Tx was granted last.
  assign rx_win   = rx2arb_trEn & (~tx2arb_trEn | last_tx_q);
  assign ack_own  = (state_q == ST_REQ) ? a_own_q : OWN_NONE;
  assign data_own = (d_own_q != OWN_NONE) ? d_own_q : a_own_q;
  // Data phase handed over on addrDn, unless its only beat already completed this cycle.
  assign d_own_d  = (d_own_q == OWN_NONE && ahbc2arb_dataDn) ? OWN_NONE : a_own_q;

  assign arb2rx_ack      = ahbc2arb_ack    & ack_own[0];
  assign arb2tx_ack      = ahbc2arb_ack    & ack_own[1];
  assign arb2rx_addrDn   = ahbc2arb_addrDn & a_own_q[0];
  assign arb2tx_addrDn   = ahbc2arb_addrDn & a_own_q[1];
  assign arb2rx_dataDn   = ahbc2arb_dataDn & data_own[0];
  assign arb2tx_dataDn   = ahbc2arb_dataDn & data_own[1];
  assign arb2eng_sWrAddr = ahbc2arb_sWrAddr;

  assign arb2ahbc_trEn    = tren_q;
  assign arb2ahbc_beats   = beats_q;
  assign arb2ahbc_hSize   = hsize_q;
  assign arb2ahbc_sWrAddr = addr_q;
  assign arb2ahbc_sRdWr   = rdwr_q;
  assign arb_aOwn         = a_own_q;
  assign arb_tmoErr       = tmo_q;

  always_ff @(posedge uctl_sysClk) begin
    if (!uctl_sysRst_n) begin
      state_q   <= ST_IDLE;
      last_tx_q <= 1'b1;
      a_own_q   <= OWN_NONE;
      d_own_q   <= OWN_NONE;
      cnt_q     <= '0;
      tren_q    <= 1'b0;
      beats_q   <= '0;
      hsize_q   <= '0;
      addr_q    <= '0;
      rdwr_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      if (ahbc2arb_dataDn && d_own_q != OWN_NONE) begin
        d_own_q <= OWN_NONE;
      end
      unique case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (any_req) begin
            state_q   <= ST_REQ;
            tren_q    <= 1'b1;
            last_tx_q <= ~rx_win;
            a_own_q   <= rx_win ? OWN_RX : OWN_TX;
            beats_q   <= rx_win ? rx2arb_beats   : tx2arb_beats;
            hsize_q   <= rx_win ? rx2arb_hSize   : tx2arb_hSize;
            addr_q    <= rx_win ? rx2arb_sWrAddr : tx2arb_sWrAddr;
            rdwr_q    <= rx_win ? rx2arb_sRdWr   : tx2arb_sRdWr;
          end
        end
        ST_REQ: begin
          if (ahbc2arb_ack) begin
            tren_q <= 1'b0;
            cnt_q  <= '0;
            if (ahbc2arb_addrDn) begin
              a_own_q <= OWN_NONE;
              d_own_q <= d_own_d;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_ADDR;
            end
          end else if (cnt_q == TMO_LAST) begin
            // Abort without acking; last_tx_q keeps favouring the other engine.
            tren_q  <= 1'b0;
            a_own_q <= OWN_NONE;
            tmo_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_ADDR: begin
          if (ahbc2arb_addrDn) begin
            a_own_q <= OWN_NONE;
            d_own_q <= d_own_d;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uctl_ahbmstrarb.sv
// Bench for uctl_ahbmstrarb: directed vector table, timeout/reset sequences, randomized run against a reference model.
module tb_uctl_ahbmstrarb;
  localparam int AW  = 32;
  localparam int TMO = 200;

  logic          clk, rst_n;
  logic          rx_tren, rx_rdwr, tx_tren, tx_rdwr;
  logic [4:0]    rx_beats, tx_beats;
  logic [2:0]    rx_hs, tx_hs;
  logic [AW-1:0] rx_addr, tx_addr;
  logic          o_rx_ack, o_rx_adn, o_rx_ddn, o_tx_ack, o_tx_adn, o_tx_ddn;
  logic [AW-1:0] o_eng_addr;
  logic          o_tren, o_rdwr;
  logic [4:0]    o_beats;
  logic [2:0]    o_hs;
  logic [AW-1:0] o_addr;
  logic          h_ack, h_adn, h_ddn;
  logic [AW-1:0] h_addr;
  logic [1:0]    o_aown;
  logic          o_tmo;
  logic [5:0]    dut_hs;

  int n_tests = 0;
  int n_fail  = 0;

  uctl_ahbmstrarb #(.ADDR_SIZE(AW), .TMO_WD(8), .TMO_CNT(TMO)) dut (
    .uctl_sysClk(clk), .uctl_sysRst_n(rst_n),
    .rx2arb_trEn(rx_tren), .rx2arb_beats(rx_beats), .rx2arb_hSize(rx_hs),
    .rx2arb_sWrAddr(rx_addr), .rx2arb_sRdWr(rx_rdwr),
    .tx2arb_trEn(tx_tren), .tx2arb_beats(tx_beats), .tx2arb_hSize(tx_hs),
    .tx2arb_sWrAddr(tx_addr), .tx2arb_sRdWr(tx_rdwr),
    .arb2rx_ack(o_rx_ack), .arb2rx_addrDn(o_rx_adn), .arb2rx_dataDn(o_rx_ddn),
    .arb2tx_ack(o_tx_ack), .arb2tx_addrDn(o_tx_adn), .arb2tx_dataDn(o_tx_ddn),
    .arb2eng_sWrAddr(o_eng_addr),
    .arb2ahbc_trEn(o_tren), .arb2ahbc_beats(o_beats), .arb2ahbc_hSize(o_hs),
    .arb2ahbc_sWrAddr(o_addr), .arb2ahbc_sRdWr(o_rdwr),
    .ahbc2arb_ack(h_ack), .ahbc2arb_addrDn(h_adn), .ahbc2arb_dataDn(h_ddn),
    .ahbc2arb_sWrAddr(h_addr),
    .arb_aOwn(o_aown), .arb_tmoErr(o_tmo)
  );

  assign dut_hs = {o_rx_ack, o_rx_adn, o_rx_ddn, o_tx_ack, o_tx_adn, o_tx_ddn};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_fields(input string name, input int who);
    if (who == 1) begin
      check({name, " beats"}, 64'(o_beats), 64'd16);
      check({name, " hsize"}, 64'(o_hs),    64'd2);
      check({name, " addr"},  64'(o_addr),  64'h1000);
      check({name, " rdwr"},  64'(o_rdwr),  64'd1);
    end else begin
      check({name, " beats"}, 64'(o_beats), 64'd8);
      check({name, " hsize"}, 64'(o_hs),    64'd1);
      check({name, " addr"},  64'(o_addr),  64'h2000);
      check({name, " rdwr"},  64'(o_rdwr),  64'd0);
    end
  endtask

  task automatic fixed_fields();
    rx_beats = 5'd16; rx_hs = 3'd2; rx_addr = 32'h1000; rx_rdwr = 1'b1;
    tx_beats = 5'd8;  tx_hs = 3'd1; tx_addr = 32'h2000; tx_rdwr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_tren = 1'b0; tx_tren = 1'b0;
    h_ack = 1'b0; h_adn = 1'b0; h_ddn = 1'b0; h_addr = '0;
    fixed_fields();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Reference model: phase 0 idle / 1 waiting for ack / 2 waiting for address done; owners 0 none, 1 Rx, 2 Tx.
  int            m_ph, m_aown, m_down, m_last, m_wait;
  bit            m_tren, m_tmo, m_rdwr;
  logic [4:0]    m_beats;
  logic [2:0]    m_hs;
  logic [AW-1:0] m_addr;

  task automatic model_reset();
    m_ph = 0; m_aown = 0; m_down = 0; m_last = 2; m_wait = 0;
    m_tren = 0; m_tmo = 0; m_beats = '0; m_hs = '0; m_addr = '0; m_rdwr = 0;
  endtask

  function automatic logic [5:0] model_hs();
    logic [5:0] r;
    int dt;
    r  = '0;
    dt = (m_down != 0) ? m_down : m_aown;
    if (m_ph == 1 && h_ack) r[(m_aown == 1) ? 5 : 2] = 1'b1;
    if (h_adn && m_aown != 0) r[(m_aown == 1) ? 4 : 1] = 1'b1;
    if (h_ddn && dt != 0) r[(dt == 1) ? 3 : 0] = 1'b1;
    return r;
  endfunction

  task automatic model_clock();
    int  win, nd;
    bit  addr_done;
    m_tmo = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    nd = h_ddn ? 0 : m_down;
    addr_done = 0;
    if (m_ph == 0) begin
      if (rx_tren || tx_tren) begin
        if (rx_tren && tx_tren) win = (m_last == 1) ? 2 : 1;
        else win = rx_tren ? 1 : 2;
        m_aown = win; m_last = win; m_tren = 1; m_wait = 0; m_ph = 1;
        m_beats = (win == 1) ? rx_beats : tx_beats;
        m_hs    = (win == 1) ? rx_hs    : tx_hs;
        m_addr  = (win == 1) ? rx_addr  : tx_addr;
        m_rdwr  = (win == 1) ? rx_rdwr  : tx_rdwr;
      end
    end else if (m_ph == 1) begin
      m_wait++;
      if (h_ack) begin
        m_tren = 0;
        if (h_adn) addr_done = 1;
        else m_ph = 2;
      end else if (m_wait == TMO) begin
        m_tren = 0; m_aown = 0; m_tmo = 1; m_ph = 0;
      end
    end else if (h_adn) begin
      addr_done = 1;
    end
    if (addr_done) begin
      nd = (m_down == 0 && h_ddn) ? 0 : m_aown;
      m_aown = 0; m_ph = 0;
    end
    m_down = nd;
  endtask

  typedef struct {
    bit       rst, rx, tx, ack, adn, ddn;
    bit       tren;
    bit [1:0] own, sel;
    bit [5:0] hs;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(bit rst, bit rx, bit tx, bit ack, bit adn, bit ddn,
                             bit tren, bit [1:0] own, bit [1:0] sel, bit [5:0] hs);
    vec_t v;
    v.rst = rst; v.rx = rx; v.tx = tx; v.ack = ack; v.adn = adn; v.ddn = ddn;
    v.tren = tren; v.own = own; v.sel = sel; v.hs = hs;
    return v;
  endfunction

  initial begin
    // hs bit order: rx_ack rx_addrDn rx_dataDn tx_ack tx_addrDn tx_dataDn
    tbl.push_back(V(0,1,0,0,0,0, 1,1,1, 6'b000000));
    tbl.push_back(V(0,1,0,0,0,0, 1,1,1, 6'b000000));
    tbl.push_back(V(0,1,0,0,0,0, 1,1,1, 6'b000000));
    tbl.push_back(V(0,1,0,1,1,0, 0,0,0, 6'b110000));
    tbl.push_back(V(0,0,0,0,0,1, 0,0,0, 6'b001000));
    tbl.push_back(V(0,0,0,1,0,0, 0,0,0, 6'b000000));
    tbl.push_back(V(1,1,1,0,0,0, 0,0,0, 6'b000000));
    tbl.push_back(V(0,1,1,0,0,0, 1,1,1, 6'b000000));
    tbl.push_back(V(0,1,1,1,1,0, 0,0,0, 6'b110000));
    tbl.push_back(V(0,0,1,0,0,1, 1,2,2, 6'b001000));
    tbl.push_back(V(0,0,1,1,1,0, 0,0,0, 6'b000110));
    tbl.push_back(V(0,1,1,0,0,1, 1,1,1, 6'b000001));
    tbl.push_back(V(0,1,1,1,0,0, 0,1,0, 6'b100000));
    tbl.push_back(V(0,0,1,0,1,0, 0,0,0, 6'b010000));
    tbl.push_back(V(0,0,1,0,0,1, 1,2,2, 6'b001000));
    tbl.push_back(V(0,1,1,1,1,0, 0,0,0, 6'b000110));
    tbl.push_back(V(0,1,0,0,0,0, 1,1,1, 6'b000000));
    tbl.push_back(V(0,1,0,0,0,1, 1,1,1, 6'b000001));
    tbl.push_back(V(0,1,0,1,0,0, 0,1,0, 6'b100000));
    tbl.push_back(V(0,0,0,0,1,0, 0,0,0, 6'b010000));
    tbl.push_back(V(0,0,1,0,0,1, 1,2,2, 6'b001000));
    tbl.push_back(V(0,0,1,1,1,0, 0,0,0, 6'b000110));
    tbl.push_back(V(0,1,0,0,0,0, 1,1,1, 6'b000000));
    tbl.push_back(V(0,1,0,1,0,0, 0,1,0, 6'b100000));
    tbl.push_back(V(0,0,0,0,1,1, 0,0,0, 6'b010001));
    tbl.push_back(V(0,0,0,0,0,1, 0,0,0, 6'b001000));
    tbl.push_back(V(0,0,1,0,0,0, 1,2,2, 6'b000000));
    tbl.push_back(V(0,0,0,0,0,0, 1,2,2, 6'b000000));
    tbl.push_back(V(0,0,0,1,1,0, 0,0,0, 6'b000110));
    tbl.push_back(V(0,0,0,0,0,1, 0,0,0, 6'b000001));

    do_reset();
    check("reset trEn",  64'(o_tren),  64'd0);
    check("reset aOwn",  64'(o_aown),  64'd0);
    check("reset tmo",   64'(o_tmo),   64'd0);
    check("reset beats", 64'(o_beats), 64'd0);
    check("reset addr",  64'(o_addr),  64'd0);
    check("reset hs",    64'(dut_hs),  64'd0);

    foreach (tbl[i]) begin
      rst_n = ~tbl[i].rst;
      rx_tren = tbl[i].rx; tx_tren = tbl[i].tx;
      h_ack = tbl[i].ack; h_adn = tbl[i].adn; h_ddn = tbl[i].ddn;
      h_addr = 32'hA000 + 32'(i);
      #1;
      check($sformatf("vec%0d handshakes", i), 64'(dut_hs), 64'(tbl[i].hs));
      check($sformatf("vec%0d engAddr", i), 64'(o_eng_addr), 64'(32'hA000 + 32'(i)));
      @(posedge clk); #1;
      rst_n = 1'b1;
      check($sformatf("vec%0d trEn", i), 64'(o_tren), 64'(tbl[i].tren));
      check($sformatf("vec%0d aOwn", i), 64'(o_aown), 64'(tbl[i].own));
      if (tbl[i].sel != 0) check_fields($sformatf("vec%0d", i), int'(tbl[i].sel));
    end

    // Watchdog: Rx granted, never acked, Tx waiting.
    do_reset();
    rx_tren = 1'b1; tx_tren = 1'b1;
    @(posedge clk); #1;
    check("tmo grant aOwn", 64'(o_aown), 64'd1);
    for (int i = 1; i < TMO; i++) begin
      @(posedge clk); #1;
      check($sformatf("tmo wait%0d tmoErr", i), 64'(o_tmo), 64'd0);
      check($sformatf("tmo wait%0d trEn", i), 64'(o_tren), 64'd1);
    end
    @(posedge clk); #1;
    check("tmo pulse", 64'(o_tmo), 64'd1);
    check("tmo trEn",  64'(o_tren), 64'd0);
    check("tmo aOwn",  64'(o_aown), 64'd0);
    @(posedge clk); #1;
    check("tmo pulse end", 64'(o_tmo), 64'd0);
    check("tmo next trEn", 64'(o_tren), 64'd1);
    check("tmo next aOwn", 64'(o_aown), 64'd2);
    check_fields("tmo next", 2);

    // Reset glitch between edges, then synchronous reset while waiting for addrDn.
    do_reset();
    rx_tren = 1'b1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("glitch trEn", 64'(o_tren), 64'd1);
    check("glitch aOwn", 64'(o_aown), 64'd1);
    h_ack = 1'b1;
    @(posedge clk); #1;
    h_ack = 1'b0; rx_tren = 1'b0;
    check("addr-ph aOwn", 64'(o_aown), 64'd1);
    check("addr-ph trEn", 64'(o_tren), 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst-addr aOwn",  64'(o_aown),  64'd0);
    check("rst-addr trEn",  64'(o_tren),  64'd0);
    check("rst-addr beats", 64'(o_beats), 64'd0);
    check("rst-addr hsize", 64'(o_hs),    64'd0);
    check("rst-addr addr",  64'(o_addr),  64'd0);
    check("rst-addr rdwr",  64'(o_rdwr),  64'd0);
    h_ack = 1'b1; h_adn = 1'b1; h_ddn = 1'b1;
    #1;
    check("rst-addr handshakes", 64'(dut_hs), 64'd0);
    @(posedge clk); #1;
    h_ack = 1'b0; h_adn = 1'b0; h_ddn = 1'b0;
    check("rst-addr idle aOwn", 64'(o_aown), 64'd0);

    // Randomized protocol-legal traffic against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      rx_tren  = 1'($urandom_range(0, 1));
      tx_tren  = 1'($urandom_range(0, 1));
      rx_beats = 5'($urandom); rx_hs = 3'($urandom); rx_addr = $urandom; rx_rdwr = 1'($urandom);
      tx_beats = 5'($urandom); tx_hs = 3'($urandom); tx_addr = $urandom; tx_rdwr = 1'($urandom);
      h_ack    = (m_ph == 1) && ($urandom_range(0, 2) == 0);
      h_adn    = ((m_ph == 1 && h_ack) || m_ph == 2) && ($urandom_range(0, 1) == 1);
      h_ddn    = (m_down != 0) && ($urandom_range(0, 2) == 0);
      h_addr   = $urandom;
      #1;
      check($sformatf("rnd%0d handshakes", c), 64'(dut_hs), 64'(model_hs()));
      check($sformatf("rnd%0d engAddr", c), 64'(o_eng_addr), 64'(h_addr));
      @(posedge clk);
      model_clock();
      #1;
      check($sformatf("rnd%0d trEn", c), 64'(o_tren), 64'(m_tren));
      check($sformatf("rnd%0d aOwn", c), 64'(o_aown), 64'(m_aown));
      check($sformatf("rnd%0d tmoErr", c), 64'(o_tmo), 64'(m_tmo));
      if (m_tren) begin
        check($sformatf("rnd%0d req", c), {o_beats, o_hs, o_addr, o_rdwr},
              {m_beats, m_hs, m_addr, m_rdwr});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
